led_counter_param: RTL and testbench

- Parametrised successor to the fixed 8-bit LED counter.
- Divides the board clock (CLK_50MHz) with a prescaler. The prescaler produces a single-cycle enable tick plus a 50%-duty divided clock output.
- A WIDTH-bit counter advances only on ticks. It supports up, down, hold and load modes, and wrap or saturate at the boundaries.
- The whole block sits in one clock domain; no derived clock drives any flop.

---
 rtl/led_counter_param.sv | 137 +++++++++++++
 tb/tb_led_counter_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_counter_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_counter_param
// Purpose  : Parametrised LED counter. A prescaler divides CLK_50MHz by DIV
//            and produces a one-cycle enable tick plus a 50%-duty divided
//            clock. A WIDTH-bit counter steps only on ticks and supports hold,
//            up, down and load, with wrap or saturate at the boundaries.
//            Everything runs in the CLK_50MHz domain; CLK_OUT is a plain
//            registered output and never clocks a flop.
// Ports    : CLK_50MHz  in           system clock, rising edge
//            Res        in           asynchronous active-low reset
//            EN         in           1 = prescaler runs, 0 = everything frozen
//            MODE       in  [1:0]    00 hold, 01 up, 10 down, 11 load
//            WRAP       in           1 = wrap at boundary, 0 = saturate
//            LOAD_VAL   in  [W-1:0]  value taken in load mode
//            LED        out [W-1:0]  counter value (registered)
//            CLK_OUT    out          divided clock, period DIV (registered)
//            TICK       out          one-cycle pulse per prescaler wrap
//            TC         out          one-cycle terminal-count pulse
// Revision : 1.0 - initial release
// ============================================================================
module led_counter_param #(
  parameter int               WIDTH   = 8,
  parameter int               DIV     = 250,  // even, >= 2
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_50MHz,
  input  logic             Res,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             WRAP,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] LED,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             TC
);

  localparam int               CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] LED_MAX  = '1;
  localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             tick_edge;
  logic             at_max, at_min;

  // A tick edge needs EN high: if EN drops while the count sits at DIV-1,
  // the count parks there and the tick fires on the first enabled edge.
  assign tick_edge = EN && (cnt_q == CNT_LAST);
  assign at_max    = (led_q == LED_MAX);
  assign at_min    = (led_q == '0);

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    led_d     = led_q;
    tick_d    = tick_edge;
    tc_d      = 1'b0;

    if (EN) begin
      if (tick_edge) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Rise at count DIV/2-1, fall on the tick edge: high for DIV/2 cycles.
    // For DIV=2 both conditions alternate, giving a toggle every cycle.
    if (tick_edge) begin
      clk_out_d = 1'b0;
    end else if (EN && (cnt_q == CNT_RISE)) begin
      clk_out_d = 1'b1;
    end

    // MODE, WRAP and LOAD_VAL only matter at the tick edge.
    if (tick_edge) begin
      case (MODE)
        MODE_UP: begin
          tc_d = at_max;
          if (at_max) begin
            led_d = WRAP ? '0 : LED_MAX;
          end else begin
            led_d = led_q + LED_ONE;
          end
        end
        MODE_DOWN: begin
          tc_d = at_min;
          if (at_min) begin
            led_d = WRAP ? LED_MAX : '0;
          end else begin
            led_d = led_q - LED_ONE;
          end
        end
        MODE_LOAD: led_d = LOAD_VAL;
        MODE_HOLD: led_d = led_q;
        default:   led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHz or negedge Res) begin
    if (!Res) begin
      cnt_q     <= '0;
      led_q     <= RST_VAL;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      tc_q      <= tc_d;
    end
  end

  assign LED     = led_q;
  assign CLK_OUT = clk_out_q;
  assign TICK    = tick_q;
  assign TC      = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_led_counter_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_led_counter_param
// Purpose  : Self-checking bench. dut8 runs the default configuration
//            (WIDTH=8, DIV=250); dut4 (WIDTH=4, DIV=4) exercises modes,
//            boundaries, EN gating and asynchronous reset. Expected LED/TC
//            values for dut4 are queued by the stimulus and checked by a
//            monitor each time dut4 raises TICK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_counter_param;

  logic       clk;
  logic       res8, en8, wrap8;
  logic [1:0] mode8;
  logic [7:0] lv8, led8;
  logic       clk_out8, tick8, tc8;

  logic       res4, en4, wrap4;
  logic [1:0] mode4;
  logic [3:0] lv4, led4;
  logic       clk_out4, tick4, tc4;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];

  led_counter_param #(.WIDTH(8), .DIV(250), .RST_VAL(8'd0)) dut8 (
    .CLK_50MHz(clk), .Res(res8), .EN(en8), .MODE(mode8), .WRAP(wrap8),
    .LOAD_VAL(lv8), .LED(led8), .CLK_OUT(clk_out8), .TICK(tick8), .TC(tc8)
  );

  led_counter_param #(.WIDTH(4), .DIV(4), .RST_VAL(4'd0)) dut4 (
    .CLK_50MHz(clk), .Res(res4), .EN(en4), .MODE(mode4), .WRAP(wrap4),
    .LOAD_VAL(lv4), .LED(led4), .CLK_OUT(clk_out4), .TICK(tick4), .TC(tc4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for dut4.
  always @(negedge clk) begin
    if (res4) begin
      checks++;
      if (tick4) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_tick actual LED=%0d TC=%0d required no tick at %0t",
                   led4, tc4, $time);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          if ({led4, tc4} !== e) begin
            errors++;
            $display("FAIL sb_tick actual LED=%0d TC=%0d required LED=%0d TC=%0d at %0t",
                     led4, tc4, e[4:1], e[0], $time);
          end
        end
      end else if (tc4 !== 1'b0) begin
        errors++;
        $display("FAIL tc_without_tick actual=%0d required=0 at %0t", tc4, $time);
      end
    end
  end

  // Issue one tick's worth of stimulus on dut4, starting right after a tick
  // (or reset release) when the prescaler count is 0. The tick edge is the
  // 4th rising edge, so TICK is seen at the 4th falling edge; CLK_OUT reads
  // 0,1,1,0 at falling edges 1..4. With glitch set, the inputs are inverted
  // between ticks and restored before the tick edge.
  task automatic do_tick(input logic [1:0] m, input logic w, input logic [3:0] lv,
                         input logic [3:0] el, input logic etc, input bit glitch);
    mode4 = m;
    wrap4 = w;
    lv4   = lv;
    exp_q.push_back({el, etc});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk((k < 4) ? "tick4_gap" : "tick4_due", tick4, (k == 4));
      chk("clk_out4_phase", clk_out4, (k == 2 || k == 3));
      if (glitch && k == 1) begin
        mode4 = ~m;
        wrap4 = ~w;
        lv4   = ~lv;
      end
      if (glitch && k == 3) begin
        mode4 = m;
        wrap4 = w;
        lv4   = lv;
      end
    end
  endtask

  initial begin
    res8 = 1'b0; en8 = 1'b1; mode8 = 2'b01; wrap8 = 1'b1; lv8 = 8'd0;
    res4 = 1'b0; en4 = 1'b1; mode4 = 2'b01; wrap4 = 1'b1; lv4 = 4'd0;

    // ---------------- default configuration ----------------
    repeat (300) @(negedge clk);
    chk("rst8_led", led8, 0);
    chk("rst8_clk_out", clk_out8, 0);
    chk("rst8_tick", tick8, 0);
    chk("rst8_tc", tc8, 0);
    chk("rst4_led", led4, 0);
    chk("rst4_clk_out", clk_out4, 0);
    repeat (300) @(negedge clk);   // 12000 ns
    res8 = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      // Falling edge k follows rising edge k after release.
      chk("d8_tick", tick8, (k == 250 || k == 500));
      chk("d8_clk_out", clk_out8, ((k % 250) >= 125));
      chk("d8_tc", tc8, 0);
      if (k == 249 || k == 250 || k == 499 || k == 500)
        chk("d8_led", led8, k / 250);
    end

    // ---------------- dut4: up with wrap ----------------
    res4 = 1'b1;
    for (int i = 1; i <= 15; i++) do_tick(2'b01, 1'b1, 4'd0, i[3:0], 1'b0, 1'b0);
    do_tick(2'b01, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    do_tick(2'b01, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);

    // Saturate at MAX: TC every tick while pinned.
    do_tick(2'b11, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
    repeat (3) do_tick(2'b01, 1'b0, 4'd0, 4'd15, 1'b1, 1'b0);

    // Hold never raises TC; inputs changed between ticks are ignored.
    do_tick(2'b00, 1'b0, 4'd0, 4'd15, 1'b0, 1'b0);
    do_tick(2'b00, 1'b1, 4'd7, 4'd15, 1'b0, 1'b1);
    do_tick(2'b01, 1'b0, 4'd0, 4'd15, 1'b1, 1'b1);

    // Load then down with wrap.
    do_tick(2'b11, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    do_tick(2'b10, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0);
    do_tick(2'b10, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    do_tick(2'b10, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    do_tick(2'b10, 1'b1, 4'd0, 4'd15, 1'b1, 1'b0);
    do_tick(2'b10, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0);

    // Load then down with saturate.
    do_tick(2'b11, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0);
    do_tick(2'b10, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);
    do_tick(2'b10, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
    do_tick(2'b10, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    do_tick(2'b10, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    do_tick(2'b10, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    do_tick(2'b11, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);   // load at 0: no TC

    // ---------------- EN gating with count = 1 ----------------
    do_tick(2'b11, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    mode4 = 2'b01;
    wrap4 = 1'b1;
    @(negedge clk);                 // count is now 1
    chk("pre_freeze_clk_out", clk_out4, 0);
    en4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("frz_tick", tick4, 0);
      chk("frz_led", led4, 9);
      chk("frz_clk_out", clk_out4, 0);
    end
    exp_q.push_back({4'd10, 1'b0});
    en4 = 1'b1;
    // Count steps 2, 3 in the two following cycles, then the tick edge.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("resume_tick", tick4, (k == 3));
    end

    // ---------------- EN drops on the would-be tick edge ----------------
    exp_q.push_back({4'd11, 1'b0});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("pre_hold_tick", tick4, 0);
    end
    en4 = 1'b0;                     // count is DIV-1
    chk("pre_hold_clk_out", clk_out4, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_last_tick", tick4, 0);
      chk("hold_last_led", led4, 10);
      chk("hold_last_clk_out", clk_out4, 1);
    end
    en4 = 1'b1;
    @(negedge clk);
    chk("release_tick", tick4, 1);

    // ---------------- asynchronous reset mid-run ----------------
    do_tick(2'b11, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_arst_clk_out", clk_out4, 1);
    chk("pre_arst_led", led4, 9);
    @(posedge clk);
    #5;
    res4 = 1'b0;
    #1;
    chk("arst_led", led4, 0);
    chk("arst_clk_out", clk_out4, 0);
    chk("arst_tick", tick4, 0);
    chk("arst_tc", tc4, 0);
    @(negedge clk);
    res4 = 1'b1;
    do_tick(2'b01, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
